cacheline_arbiter: RTL and testbench

CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

---
 rtl/cacheline_arbiter.sv | 71 +++++++
 tb/tb_cacheline_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin arbiter sharing one cacheline memory port between icache and dcache
module cacheline_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_read,
  output logic [LINE_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [LINE_WIDTH-1:0] dmem_wdata,
  output logic [LINE_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  spurious_resp
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state;
  logic last_d;
  logic pend_i, pend_d, grant_d;
  assign pend_i = imem_read;
  assign pend_d = dmem_read | dmem_write;
  // on a tie the side not granted last wins
  assign grant_d = pend_d & (~pend_i | ~last_d);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      last_d        <= 1'b0;
      mem_addr      <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_wdata     <= '0;
      spurious_resp <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_resp) spurious_resp <= 1'b1;
          if (pend_i | pend_d) begin
            state     <= grant_d ? BUSY_D : BUSY_I;
            last_d    <= grant_d;
            mem_addr  <= grant_d ? dmem_addr : imem_addr;
            mem_read  <= grant_d ? ~dmem_write : 1'b1;
            mem_write <= grant_d & dmem_write;
            if (grant_d) mem_wdata <= dmem_wdata;
          end
        end
        default: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
      endcase
    end
  end
  // responses are gated by reset so an abandoned transaction never completes
  assign imem_resp  = rst & (state == BUSY_I) & mem_resp;
  assign dmem_resp  = rst & (state == BUSY_D) & mem_resp;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed and randomized checks against a transaction-level arbiter model
module tb_cacheline_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] imem_addr = '0, dmem_addr = '0;
  logic imem_read = 1'b0, dmem_read = 1'b0, dmem_write = 1'b0, mem_resp = 1'b0;
  logic [LW-1:0] dmem_wdata = '0, mem_rdata = '0;
  logic [LW-1:0] imem_rdata, dmem_rdata, mem_wdata;
  logic imem_resp, dmem_resp, mem_read, mem_write, spurious_resp;
  logic [AW-1:0] mem_addr;
  always #5 clk = ~clk;
  cacheline_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_read(imem_read), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .spurious_resp(spurious_resp)
  );
  int n_chk = 0;
  int n_pass = 0;
  // model: who owns the memory port (0 none, 1 icache, 2 dcache) and the command it issued
  int m_owner = 0;
  logic m_last_d = 1'b0, m_rd = 1'b0, m_wr = 1'b0, m_spur = 1'b0, live = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic i_done = 1'b0, d_done = 1'b0;
  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic model_edge();
    bit take_d, want_i, want_d;
    want_i = imem_read;
    want_d = dmem_read | dmem_write;
    if (!rst) begin
      m_owner = 0; m_last_d = 0; m_rd = 0; m_wr = 0; m_spur = 0; m_addr = '0; m_wdata = '0; live = 1;
    end else if (m_owner == 0) begin
      if (mem_resp) m_spur = 1;
      if (want_i || want_d) begin
        take_d = (want_i && want_d) ? !m_last_d : want_d;
        m_owner = take_d ? 2 : 1;
        m_last_d = take_d;
        m_addr = take_d ? dmem_addr : imem_addr;
        m_wr = take_d && dmem_write;
        m_rd = !m_wr;
        if (take_d) m_wdata = dmem_wdata;
      end
    end else if (mem_resp) begin
      m_owner = 0; m_rd = 0; m_wr = 0;
    end
  endtask
  task automatic tick();
    #1;
    if (live) begin
      chk("mem_read", LW'(mem_read), LW'(m_rd));
      chk("mem_write", LW'(mem_write), LW'(m_wr));
      chk("mem_addr", LW'(mem_addr), LW'(m_addr));
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("imem_resp", LW'(imem_resp), LW'(rst && m_owner == 1 && mem_resp));
      chk("dmem_resp", LW'(dmem_resp), LW'(rst && m_owner == 2 && mem_resp));
      chk("imem_rdata", imem_rdata, mem_rdata);
      chk("dmem_rdata", dmem_rdata, mem_rdata);
      chk("spurious", LW'(spurious_resp), LW'(m_spur));
      chk("d_rw_excl", LW'(dmem_read & dmem_write), LW'(0));
    end
    i_done = imem_resp;
    d_done = dmem_resp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic wait_cmd();
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin tick(); n++; end
    chk("cmd_timeout", LW'(n < 20), LW'(1));
  endtask
  task automatic respond(input int delay);
    repeat (delay) tick();
    mem_resp = 1'b1;
    mem_rdata = rand_line();
    tick();
    mem_resp = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask
  initial begin
    logic [LW-1:0] pat;
    int cnt;
    bit w;
    pat = {32{8'hA5}};
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;
    // icache-only fill, memory answers 5 cycles after the command
    imem_addr = 32'h0000_1000;
    imem_read = 1'b1;
    tick();
    chk("t1_cmd", LW'(mem_read), LW'(1));
    chk("t1_addr", LW'(mem_addr), LW'(32'h1000));
    repeat (5) tick();
    mem_resp = 1'b1;
    mem_rdata = rand_line();
    #1;
    chk("t1_iresp", LW'(imem_resp), LW'(1));
    chk("t1_idata", imem_rdata, mem_rdata);
    chk("t1_dresp", LW'(dmem_resp), LW'(0));
    tick();
    mem_resp = 1'b0;
    imem_read = 1'b0;
    tick();
    chk("t1_done", LW'(mem_read), LW'(0));
    // tie right after reset goes to dcache, icache follows two cycles after dmem_resp
    rst = 1'b0;
    tick();
    rst = 1'b1;
    imem_addr = 32'h3000; dmem_addr = 32'h4000;
    imem_read = 1'b1; dmem_read = 1'b1;
    tick();
    chk("t2_first_d", LW'(mem_addr), LW'(32'h4000));
    respond(1);
    dmem_read = 1'b0;
    chk("t2_gap", LW'(mem_read), LW'(0));
    tick();
    chk("t2_i_cmd", LW'(mem_read), LW'(1));
    chk("t2_i_addr", LW'(mem_addr), LW'(32'h3000));
    respond(2);
    imem_read = 1'b0;
    tick();
    // both held pending: strict alternation D, I, D, I
    imem_addr = 32'h5000; dmem_addr = 32'h6000;
    imem_read = 1'b1; dmem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cmd();
      chk($sformatf("t3_order%0d", k), LW'(mem_addr), LW'(k % 2 == 0 ? 32'h6000 : 32'h5000));
      respond(k);
    end
    imem_read = 1'b0; dmem_read = 1'b0;
    tick();
    // dcache writeback keeps its data stable even when the requester changes it
    dmem_addr = 32'h0000_2040;
    dmem_wdata = pat;
    dmem_write = 1'b1;
    tick();
    chk("t4_wr", LW'(mem_write), LW'(1));
    chk("t4_rd", LW'(mem_read), LW'(0));
    chk("t4_addr", LW'(mem_addr), LW'(32'h2040));
    chk("t4_wdata", mem_wdata, pat);
    dmem_wdata = rand_line();
    repeat (3) tick();
    chk("t4_stable", mem_wdata, pat);
    respond(0);
    dmem_write = 1'b0;
    tick();
    // memory answers with nothing outstanding
    chk("t5_pre", LW'(spurious_resp), LW'(0));
    mem_resp = 1'b1;
    #1;
    chk("t5_no_iresp", LW'(imem_resp), LW'(0));
    chk("t5_no_dresp", LW'(dmem_resp), LW'(0));
    tick();
    mem_resp = 1'b0;
    chk("t5_spur", LW'(spurious_resp), LW'(1));
    repeat (3) tick();
    chk("t5_sticky", LW'(spurious_resp), LW'(1));
    // reset during an icache fill, then a late memory response
    do_reset();
    chk("t6_spur_clr", LW'(spurious_resp), LW'(0));
    imem_addr = 32'h7000;
    imem_read = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rd_drop", LW'(mem_read), LW'(0));
    rst = 1'b1;
    imem_read = 1'b0;
    mem_resp = 1'b1;
    #1;
    chk("t6_no_iresp", LW'(imem_resp), LW'(0));
    tick();
    mem_resp = 1'b0;
    chk("t6_late_spur", LW'(spurious_resp), LW'(1));
    dmem_addr = 32'h8000;
    dmem_read = 1'b1;
    tick();
    chk("t6_idle_grant", LW'(mem_read), LW'(1));
    chk("t6_idle_addr", LW'(mem_addr), LW'(32'h8000));
    respond(0);
    dmem_read = 1'b0;
    tick();
    // randomized well-behaved requesters and memory
    do_reset();
    cnt = -1;
    repeat (400) begin
      if (i_done) imem_read = 1'b0;
      else if (!imem_read && $urandom_range(2) == 0) begin
        imem_addr = $urandom & ~32'h1f;
        imem_read = 1'b1;
      end
      if (d_done) begin dmem_read = 1'b0; dmem_write = 1'b0; end
      else if (!(dmem_read || dmem_write) && $urandom_range(2) == 0) begin
        dmem_addr = $urandom & ~32'h1f;
        dmem_wdata = rand_line();
        w = 1'($urandom_range(1));
        dmem_write = w;
        dmem_read = !w;
      end
      mem_rdata = rand_line();
      mem_resp = 1'b0;
      if (mem_read || mem_write) begin
        if (cnt < 0) cnt = int'($urandom_range(3));
        if (cnt == 0) begin mem_resp = 1'b1; cnt = -1; end
        else cnt--;
      end
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
